// File: rtl/cdc_level_event_filter_if.sv
// Bundle of the filter's control inputs and event outputs.
// The master side (stimulus / register block) drives the controls and the
// synchronized level; the slave side is the filter itself.
interface cdc_level_event_filter_if #(
  parameter int FILT_W = 4,
  parameter int CNT_W  = 8
);
  logic              sync_in;
  logic [FILT_W-1:0] filt_len;
  logic [1:0]        edge_sel;
  logic              ack;
  logic              cnt_clr;
  logic              level_out;
  logic              event_pulse;
  logic              irq_pending;
  logic              overrun;
  logic [CNT_W-1:0]  event_cnt;

  modport master (
    output sync_in, filt_len, edge_sel, ack, cnt_clr,
    input  level_out, event_pulse, irq_pending, overrun, event_cnt
  );

  modport slave (
    input  sync_in, filt_len, edge_sel, ack, cnt_clr,
    output level_out, event_pulse, irq_pending, overrun, event_cnt
  );
endinterface

// File: rtl/cdc_level_event_filter.sv
// Destination-domain post-processing of a synchronized level: glitch filter
// with programmable stable length, edge-selectable event detection, sticky
// interrupt-pending flag with overrun, and a saturating event counter.
module cdc_level_event_filter #(
  parameter int   FILT_W     = 4,
  parameter int   CNT_W      = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  cdc_level_event_filter_if.slave bus
);

  localparam logic [FILT_W-1:0] STAB_ONE = {{(FILT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              level_p1;
  logic [FILT_W-1:0] stab_cnt_p1;
  logic              event_pulse_p1;
  logic              irq_pending_p1;
  logic              overrun_p1;
  logic [CNT_W-1:0]  event_cnt_p1;

  logic              differ_p0;
  logic              commit_p0;
  logic              event_p0;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // ---- stage p0: compare input against filtered level, decide commit/event
  // filt_len is compared live, so lowering it mid-count commits on the next edge.
  always_comb begin
    differ_p0 = (bus.sync_in != level_p1);
    commit_p0 = differ_p0 && (stab_cnt_p1 >= bus.filt_len);
    event_p0  = commit_p0 && (( bus.sync_in && bus.edge_sel[0]) ||
                              (!bus.sync_in && bus.edge_sel[1]));
  end

  // ---- stage p1: registered filter state and event bookkeeping
  // Stability counter and filtered level; a reset discards any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_p1    <= INIT_LEVEL;
      stab_cnt_p1 <= '0;
    end else if (!differ_p0) begin
      stab_cnt_p1 <= '0;
    end else if (commit_p0) begin
      level_p1    <= bus.sync_in;
      stab_cnt_p1 <= '0;
    end else begin
      stab_cnt_p1 <= stab_cnt_p1 + STAB_ONE;
    end
  end

  // One-cycle event pulse aligned with the newly committed level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) event_pulse_p1 <= 1'b0;
    else     event_pulse_p1 <= event_p0;
  end

  // Sticky pending flag and overrun; a new event wins over a simultaneous ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pending_p1 <= 1'b0;
      overrun_p1     <= 1'b0;
    end else begin
      irq_pending_p1 <= event_p0 | (irq_pending_p1 & ~bus.ack);
      overrun_p1     <= ~bus.ack & (overrun_p1 | (event_p0 & irq_pending_p1));
    end
  end

  // Saturating event counter; clear together with an event counts that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_cnt_p1 <= '0;
    end else if (bus.cnt_clr) begin
      event_cnt_p1 <= event_p0 ? CNT_ONE : '0;
    end else if (event_p0) begin
      event_cnt_p1 <= sat_inc(event_cnt_p1);
    end
  end

  assign bus.level_out   = level_p1;
  assign bus.event_pulse = event_pulse_p1;
  assign bus.irq_pending = irq_pending_p1;
  assign bus.overrun     = overrun_p1;
  assign bus.event_cnt   = event_cnt_p1;

endmodule

// File: tb/tb_cdc_level_event_filter.sv
// Directed bench for cdc_level_event_filter with an event scoreboard:
// stimulus pushes the expected cycle/state of every qualifying event and a
// negedge monitor pops and compares whenever event_pulse is seen.
module tb_cdc_level_event_filter;

  localparam int FILT_W = 4;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;

  cdc_level_event_filter_if #(.FILT_W(FILT_W), .CNT_W(CNT_W)) bus ();

  cdc_level_event_filter #(
    .FILT_W    (FILT_W),
    .CNT_W     (CNT_W),
    .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int   cyc;
    logic lvl;
    logic pend;
    logic ovr;
    int   cnt;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed event_pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && bus.event_pulse) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: pulse at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cyc != e.cyc || bus.level_out !== e.lvl || bus.irq_pending !== e.pend ||
            bus.overrun !== e.ovr || int'(bus.event_cnt) != e.cnt) begin
          fails++;
          $display("FAIL event: got cyc=%0d lvl=%0b pend=%0b ovr=%0b cnt=%0d, expected cyc=%0d lvl=%0b pend=%0b ovr=%0b cnt=%0d",
                   cyc, bus.level_out, bus.irq_pending, bus.overrun, bus.event_cnt,
                   e.cyc, e.lvl, e.pend, e.ovr, e.cnt);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic expect_event(input int at, input logic lvl, input logic pend,
                              input logic ovr, input int cnt);
    exp_t e;
    e.cyc = at; e.lvl = lvl; e.pend = pend; e.ovr = ovr; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1; tick(1); bus.ack = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.cnt_clr = 1'b1; tick(1); bus.cnt_clr = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    bus.sync_in  = 1'b0;
    bus.filt_len = 4'd3;
    bus.edge_sel = 2'b01;
    bus.ack      = 1'b0;
    bus.cnt_clr  = 1'b0;
    #2 rst = 1'b1;
    tick(3);
    check("rst_level", bus.level_out, 0);
    check("rst_pulse", bus.event_pulse, 0);
    check("rst_pend",  bus.irq_pending, 0);
    check("rst_ovr",   bus.overrun, 0);
    check("rst_cnt",   bus.event_cnt, 0);
    rst = 1'b0;
    tick(5);

    // 1: rising edge through filt_len = 3
    bus.sync_in = 1'b1;
    expect_event(cyc + 4, 1'b1, 1'b1, 1'b0, 1);
    tick(3);
    check("t1_level_before", bus.level_out, 0);
    tick(1);
    check("t1_level_commit", bus.level_out, 1);
    check("t1_pulse_high", bus.event_pulse, 1);
    tick(1);
    check("t1_pulse_low", bus.event_pulse, 0);
    check("t1_pend", bus.irq_pending, 1);
    check("t1_cnt", bus.event_cnt, 1);
    pulse_ack();
    check("t1_ack_pend", bus.irq_pending, 0);
    pulse_clr();
    check("t1_clr_cnt", bus.event_cnt, 0);

    // 2: glitch rejection (falling edge does not qualify with edge_sel = 01)
    bus.sync_in = 1'b0;
    tick(5);
    check("t2_level_low", bus.level_out, 0);
    for (int w = 1; w <= 3; w++) begin
      bus.sync_in = 1'b1; tick(w);
      bus.sync_in = 1'b0; tick(3);
      check("t2_glitch_level", bus.level_out, 0);
    end
    check("t2_glitch_cnt", bus.event_cnt, 0);
    bus.sync_in = 1'b1;
    expect_event(cyc + 4, 1'b1, 1'b1, 1'b0, 1);
    tick(4);
    check("t2_pulse4_level", bus.level_out, 1);
    bus.sync_in = 1'b0;
    tick(6);
    check("t2_back_low", bus.level_out, 0);
    check("t2_cnt", bus.event_cnt, 1);
    pulse_ack();

    // 3: both edges, filt_len = 0, overrun on second unacked event
    bus.edge_sel = 2'b11;
    bus.filt_len = 4'd0;
    for (int i = 0; i < 6; i++) begin
      bus.sync_in = ~bus.sync_in;
      expect_event(cyc + 1, bus.sync_in, 1'b1, (i >= 1), i + 2);
      tick(4);
    end
    check("t3_ovr", bus.overrun, 1);
    check("t3_cnt", bus.event_cnt, 7);

    // 4: ack coincident with event, then ack alone
    bus.sync_in = 1'b1;
    bus.ack     = 1'b1;
    expect_event(cyc + 1, 1'b1, 1'b1, 1'b0, 8);
    tick(1);
    bus.ack = 1'b0;
    check("t4_pend_kept", bus.irq_pending, 1);
    check("t4_ovr_clr", bus.overrun, 0);
    pulse_ack();
    check("t4_pend_ack", bus.irq_pending, 0);
    check("t4_ovr_ack", bus.overrun, 0);

    // 5: saturation and counter clear interactions
    for (int i = 0; i < 20; i++) begin
      bus.sync_in = ~bus.sync_in;
      expect_event(cyc + 1, bus.sync_in, 1'b1, (i > 0), (9 + i > 15) ? 15 : 9 + i);
      tick(2);
    end
    check("t5_sat", bus.event_cnt, 15);
    bus.sync_in = ~bus.sync_in;
    bus.cnt_clr = 1'b1;
    expect_event(cyc + 1, bus.sync_in, 1'b1, 1'b1, 1);
    tick(1);
    bus.cnt_clr = 1'b0;
    check("t5_clr_evt", bus.event_cnt, 1);
    pulse_clr();
    check("t5_clr_only", bus.event_cnt, 0);

    // 6: asynchronous reset mid-filter and mid-pending
    bus.filt_len = 4'd3;
    bus.edge_sel = 2'b01;
    bus.sync_in  = 1'b1;
    tick(2);
    check("t6_pend_before", bus.irq_pending, 1);
    check("t6_ovr_before", bus.overrun, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_level", bus.level_out, 0);
    check("t6_async_pend", bus.irq_pending, 0);
    check("t6_async_ovr", bus.overrun, 0);
    check("t6_async_cnt", bus.event_cnt, 0);
    check("t6_async_pulse", bus.event_pulse, 0);
    tick(1);
    rst = 1'b0;
    expect_event(cyc + 4, 1'b1, 1'b1, 1'b0, 1);
    tick(3);
    check("t6_restart_level", bus.level_out, 0);
    tick(1);
    check("t6_commit_level", bus.level_out, 1);
    tick(2);

    // Every expected event must have been observed.
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d outstanding expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
